// File: rtl/uart_rx_deserialiser.sv
// 8N1 UART receive deserialiser, 16x oversampled, centre-of-bit sampling.
// Good bytes and framing errors are reported as single-cycle pulses.
module uart_rx_deserialiser #(
  parameter int unsigned BAUD_DIV = 163
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       serialRx,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       frameErr,
  output logic       rxBusy
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAITHI
  } state_e;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] div_q;
  logic          tick;
  logic          rxs;

  state_e        state_q, state_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rxs  = sync2_q;
  assign tick = (div_q == DIV_MAX);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= '0;
      state_q <= S_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= serialRx;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            scnt_d  = '0;
          end
        end
        S_START: begin
          if (scnt_q == 4'd7) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = rxs ? S_IDLE : S_DATA;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (scnt_q == 4'd15) begin
            shift_d = {rxs, shift_q[7:1]};
            scnt_d  = '0;
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = S_STOP;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (scnt_q == 4'd15) begin
            scnt_d = '0;
            // Leaving at the stop centre lets a back-to-back start be seen.
            if (rxs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAITHI;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_WAITHI: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rxData   = data_q;
  assign rxValid  = valid_q;
  assign frameErr = ferr_q;
  assign rxBusy   = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_deserialiser.md
Name: uart_rx_deserialiser

Overview:
- Serial receive front end for the AHB UART peripheral.
- Takes the raw asynchronous serialRx pin and recovers 8N1 frames using 16x oversampling with centre-of-bit sampling.
- Each good byte is pushed as a one-cycle pulse into the UART's receive FIFO.
- Sits directly upstream of the rx buffer that feeds the RXDATA register and the rx interrupt logic.

Parameters:
- BAUD_DIV, 163, HCLK cycles per oversample tick (50 MHz / (19200 x 16) rounded); legal range 2..65535.

Ports:
- HCLK  input  1  bus clock; all logic on rising edge.
- HRESET  input  1  synchronous reset, active high.
- serialRx  input  1  asynchronous serial line, idle high.
- rxData  output  8  last correctly received byte.
- rxValid  output  1  one-cycle pulse when rxData has been updated with a new byte.
- frameErr  output  1  one-cycle pulse when the stop bit is sampled low.
- rxBusy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Clock and reset: single clock HCLK; reset is synchronous and active-high on HRESET. All state is updated only on the HCLK rising edge.
- Reset values: rxData=8'h00, rxValid=0, frameErr=0, rxBusy=0, state=IDLE, all counters 0, both synchroniser flops=1.
- Synchroniser: two flops on serialRx; rxs is the second flop output. Fixed latency of 2 HCLK cycles; rxs is the only line sample used.
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1, width $clog2(BAUD_DIV).
  - tick=1 for the single cycle when the counter equals BAUD_DIV-1, then it wraps to 0.
  - Never stops, including in IDLE.
- All counters below advance only on tick cycles.
- Counters: scnt is 4 bits (0..15); bcnt is 3 bits plus a done flag, or 4 bits (0..8).
- State machine:
  - IDLE: on tick with rxs=0 -> START, scnt=0.
  - START: on tick scnt++. When scnt==7 (start-bit centre): if rxs=0 -> DATA, scnt=0, bcnt=0; if rxs=1 (glitch) -> IDLE, no output.
  - DATA: on tick scnt++. When scnt==15: shift = {rxs, shift[7:1]} (LSB first), scnt=0, bcnt++. After the 8th bit -> STOP.
  - STOP: on tick scnt++. When scnt==15 and rxs=1: rxData<=shift, rxValid=1 for the next cycle, -> IDLE. When scnt==15 and rxs=0: frameErr=1 for the next cycle, rxData unchanged, -> WAITHI.
  - WAITHI: -> IDLE on the first tick with rxs=1. A held-low line (break) never produces a second frame.
- Pulse width: rxValid and frameErr are exactly 1 HCLK cycle wide, regardless of BAUD_DIV. They are never high together.
- Latency: rxValid rises 2 + (16x9 + 8)xBAUD_DIV HCLK cycles (+/-1 tick) after the serialRx falling edge of the start bit, i.e. at the stop-bit centre.
- Back-to-back frames: the next start bit may begin immediately after the stop-bit centre. Returning to IDLE at the stop centre guarantees this is detected.
- Reset mid-frame: reset returns the block to IDLE. No rxValid or frameErr is produced for the partial frame, and rxData returns to 0.
- rxData holds its value until the next good frame. There is no overrun handling here; the downstream FIFO owns overrun.

Test Plan:
- Single byte: BAUD_DIV=4, send 8N1 frame 0x78 at 64 HCLK per bit -> exactly one rxValid pulse, rxData=8'h78, frameErr never high, rxBusy high from ~1 tick after the start edge until stop centre.
- Back-to-back: frames 0x56 then 0x34 with no idle gap -> two rxValid pulses, rxData=0x56 then 0x34, spacing 640 HCLK +/-4.
- Glitch rejection: serialRx low for 20 HCLK (<8 ticks at BAUD_DIV=4), then high -> no rxValid, no frameErr, rxBusy returns to 0 within 8 ticks.
- Framing error and break: frame 0xA5 with stop bit 0, line held low 3 bit times, then 0x3C sent -> one frameErr pulse, no rxValid for 0xA5, no spurious frame during the break, then rxValid with rxData=0x3C.
- Reset mid-frame: assert HRESET for 1 cycle during bit 4 of frame 0xFF -> rxData=0, no pulses, then the next frame 0x12 is received correctly.
- Default parameter: BAUD_DIV=163, 19200-baud frame 0x00 -> rxValid with rxData=0x00; latency within +/-163 cycles of 2+152x163.
